// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default framing constants
// used by the RX, TX and mux stages.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 434;
    localparam int unsigned DATA_BITS_DEF    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM behind a 2-flop synchronizer,
// with one-cycle rx_valid / frame_err pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [15:0] HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_t       state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;

    uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            // Re-check the start bit at its midpoint so short glitches are rejected.
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            // Returning to IDLE mid-stop-bit leaves time to catch a back-to-back start edge.
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: serial frames are driven from a bit-level
// description and every output pulse is scored against a queue of expected frame outcomes.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: one entry per frame that must produce a pulse.
    bit        exp_is_err[$];
    logic [7:0] exp_byte[$];
    logic [7:0] model_data = 8'h00;
    longint    cyc = 0;
    longint    valid_times[$];
    bit        prev_pulse = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        bit         e;
        logic [7:0] d;
        if (rx_valid || frame_err) begin
            check("pulse_excl", 32'(rx_valid & frame_err), 32'd0);
            check("pulse_width", 32'(prev_pulse), 32'd0);
            if (exp_is_err.size() == 0) begin
                check("unexpected_pulse", 32'(rx_valid) | (32'(frame_err) << 1), 32'd0);
            end else begin
                e = exp_is_err.pop_front();
                d = exp_byte.pop_front();
                check("pulse_kind_ferr", 32'(frame_err), 32'(e));
                if (rx_valid) begin
                    check("rx_data", 32'(rx_data), 32'(d));
                    check("busy_at_valid", 32'(busy), 32'd0);
                    model_data = d;
                    valid_times.push_back(cyc);
                end else begin
                    check("ferr_keeps_data", 32'(rx_data), 32'(model_data));
                end
            end
        end
        prev_pulse = rx_valid | frame_err;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int low_tail);
        exp_is_err.push_back(!stop_ok);
        exp_byte.push_back(b);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < DB; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(posedge clk);
        if (low_tail > 0) begin
            rx = 1'b0;
            repeat (low_tail) @(posedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4000; i++) begin
            if (exp_is_err.size() == 0) break;
            @(posedge clk);
        end
        check(tag, 32'(exp_is_err.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] abort_byte;
        int         quiet_bad;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_outputs", {29'd0, rx_valid, frame_err, busy}, 32'd0);
        @(posedge clk);
        rst = 1'b0;

        // Idle line after reset: nothing may move.
        quiet_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rx_valid || frame_err || busy || rx_data != 0) quiet_bad++;
        end
        check("idle_quiet", 32'(quiet_bad), 32'd0);

        @(posedge clk);
        send_frame(8'hA5, 1'b1, 0);
        idle(3 * CPB);
        drain("a5_drain");
        check("a5_data", 32'(rx_data), 32'h0A5);

        valid_times.delete();
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        idle(3 * CPB);
        drain("b2b_drain");
        check("b2b_count", 32'(valid_times.size()), 32'd2);
        if (valid_times.size() == 2)
            check("b2b_spacing", 32'(valid_times[1] - valid_times[0]), 32'd160);

        rx = 1'b0;
        repeat (5) @(posedge clk);
        idle(3 * CPB);
        @(negedge clk);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_data", 32'(rx_data), 32'h0FF);

        @(posedge clk);
        send_frame(8'h3C, 1'b0, 400);
        idle(3 * CPB);
        drain("break_drain");
        check("break_keeps_data", 32'(rx_data), 32'h0FF);
        send_frame(8'h81, 1'b1, 0);
        idle(3 * CPB);
        drain("after_break_drain");
        check("after_break_data", 32'(rx_data), 32'h081);

        // Upper nibble high so the line stays idle once the aborted frame's tail runs out.
        abort_byte = 8'hF0 | 8'($urandom_range(0, 15));
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = abort_byte[i];
            repeat (CPB) @(posedge clk);
        end
        rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        rst = 1'b1;
        model_data = 8'h00;
        @(posedge clk);
        rst = 1'b0;
        repeat (CPB / 2 - 1 + 4 * CPB) @(posedge clk);
        idle(CPB);
        @(negedge clk);
        check("abort_data", 32'(rx_data), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        send_frame(8'h5A, 1'b1, 0);
        idle(3 * CPB);
        drain("abort_next_drain");
        check("abort_next_data", 32'(rx_data), 32'h05A);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            bit         ok;
            int         gap;
            b   = 8'($urandom);
            ok  = ($urandom_range(0, 7) != 0);
            gap = ok ? int'($urandom_range(0, 2 * CPB)) : CPB + int'($urandom_range(0, CPB));
            send_frame(b, ok, 0);
            idle(gap);
        end
        idle(3 * CPB);
        drain("rand_drain");
        @(negedge clk);
        check("rand_final_data", 32'(rx_data), 32'(model_data));
        check("rand_final_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 The module SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (8N1 framing).
REQ-003 The module SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 The module SHALL have port rx, input, 1, an asynchronous serial line that idles high.
REQ-006 The module SHALL have port rx_data, output, DATA_BITS, the last correctly received byte, LSB received first.
REQ-007 The module SHALL have port rx_valid, output, 1, a one-cycle pulse when rx_data updates.
REQ-008 The module SHALL have port frame_err, output, 1, a one-cycle pulse when a stop bit is sampled low.
REQ-009 The module SHALL have port busy, output, 1, which is high whenever the state is not IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer before any use; rx_s denotes its output (2-cycle latency).
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH, using a bit-period counter cnt (16 bit) and bit index idx (3 bit).
REQ-012 In IDLE, rx_s==0 SHALL move to START with cnt=0; otherwise the FSM SHALL stay in IDLE.
REQ-013 In START, at cnt==CLKS_PER_BIT/2-1 (integer divide), rx_s==0 SHALL move to DATA with cnt=0 and idx=0; rx_s==1 SHALL count as a glitch and return to IDLE with no output pulse.
REQ-014 In DATA, at cnt==CLKS_PER_BIT-1, rx_s SHALL shift into shreg[idx] and cnt SHALL reset to 0; when idx==DATA_BITS-1 the FSM SHALL move to STOP, otherwise idx SHALL increment.
REQ-015 In STOP, at cnt==CLKS_PER_BIT-1 with rx_s==1, the block SHALL set rx_data=shreg, pulse rx_valid on the next cycle, and return to IDLE.
REQ-016 In STOP, at cnt==CLKS_PER_BIT-1 with rx_s==0, the block SHALL pulse frame_err, leave rx_data unchanged, and move to WAIT_HIGH.
REQ-017 WAIT_HIGH SHALL hold until rx_s==1, then move to IDLE; a held-low break line SHALL therefore produce exactly one frame_err.
REQ-018 Sampling SHALL occur mid-bit: each sample falls at CLKS_PER_BIT/2 plus k*CLKS_PER_BIT cycles after the synchronized falling edge.
REQ-019 A start edge arriving in the same cycle the FSM returns to IDLE from STOP SHALL be detected on the following cycle, with no frame lost at the back-to-back boundary.
REQ-020 rx_valid and frame_err SHALL be mutually exclusive and never high for more than one consecutive cycle.
REQ-021 cnt SHALL never wrap; it SHALL reset on every bit boundary.

Reset
REQ-022 rst SHALL set the state to IDLE, cnt=0, idx=0, shreg=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, and both synchronizer flops to 1.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no rx_valid or frame_err pulse, and reception SHALL resume on the first falling edge after reset is released.

Structure
REQ-024 Package uart_pkg SHALL hold the state enum uart_rx_state_t and the default constants CLKS_PER_BIT_DEF=434 and DATA_BITS_DEF=8, shared with the TX and mux stages.
REQ-025 The synchronizer SHALL be a separate sub-module uart_sync (2 flops, reset value 1); everything else SHALL stay flat in uart_rx.
REQ-026 rx_data from this block SHALL feed the data input of the downstream RX select multiplexer, with no additional registering.

Verification (CLKS_PER_BIT=16)
REQ-027 Send 0xA5 with a valid stop bit -> one rx_valid pulse, rx_data=0xA5, frame_err never high, busy low again within 1 cycle of the pulse.
REQ-028 Send 0x00, then 0xFF, back-to-back with no idle gap -> two rx_valid pulses, 160 cycles apart, carrying 0x00 then 0xFF.
REQ-029 Drive a 5-cycle low glitch on idle rx -> the FSM returns to IDLE, with no rx_valid and no frame_err.
REQ-030 Send 0x3C with the stop bit low, then hold rx low for 400 cycles -> exactly one frame_err, rx_data keeps its prior value, and the next valid frame 0x81 is received correctly.
REQ-031 Assert rst for 1 cycle during DATA bit 4 of a frame -> no pulse for that frame, and the next frame 0x5A gives rx_data=0x5A.
REQ-032 After reset with rx idle -> all outputs 0 and busy 0 for 1000 cycles.
